// File: rtl/pipe_stage_chain_pkg.sv
// Shared types for the pipeline stage chain: fixed-width stage fields,
// the per-edge stage operation and its priority decode.
package pipe_stage_chain_pkg;

  localparam int INSTR_W = 32;
  localparam int EXC_W   = 5;

  // Fixed-width part of a stage record; rs/rt/pc widths are parameters of the chain.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [EXC_W-1:0]   exc;
    logic               bd;
    logic               valid;
  } stage_ctl_t;

  localparam stage_ctl_t CTL_BUBBLE = '0;

  typedef enum logic [1:0] {
    OP_ADVANCE,
    OP_BUBBLE,
    OP_HOLD,
    OP_KILL
  } stage_op_t;

  // Priority per edge: req > stall > bubble > advance (reset is handled by the flops).
  function automatic stage_op_t stage_op(input logic req, input logic stall, input logic bubble);
    if (req)    return OP_KILL;
    if (stall)  return OP_HOLD;
    if (bubble) return OP_BUBBLE;
    return OP_ADVANCE;
  endfunction

  function automatic stage_ctl_t bubble_ctl(input logic bd);
    stage_ctl_t c;
    c    = CTL_BUBBLE;
    c.bd = bd;
    return c;
  endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Handshake/data bundle between the decode-side driver and the stage chain.
interface pipe_stage_chain_if #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  import pipe_stage_chain_pkg::*;

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic               stall;
  logic               flush;
  logic               req;
  logic [INSTR_W-1:0] instr_in;
  logic [DATA_W-1:0]  rs_in;
  logic [DATA_W-1:0]  rt_in;
  logic [PC_W-1:0]    pc_in;
  logic [EXC_W-1:0]   exc_in;
  logic               bd_in;
  logic               valid_in;

  logic [INSTR_W-1:0] instr_out;
  logic [DATA_W-1:0]  rs_out;
  logic [DATA_W-1:0]  rt_out;
  logic [PC_W-1:0]    pc_out;
  logic [EXC_W-1:0]   exc_out;
  logic               bd_out;
  logic               valid_out;
  logic [OCC_W-1:0]   occ;
  logic               empty;

  modport master (
    output stall, flush, req, instr_in, rs_in, rt_in, pc_in, exc_in, bd_in, valid_in,
    input  instr_out, rs_out, rt_out, pc_out, exc_out, bd_out, valid_out, occ, empty
  );

  modport slave (
    input  stall, flush, req, instr_in, rs_in, rt_in, pc_in, exc_in, bd_in, valid_in,
    output instr_out, rs_out, rt_out, pc_out, exc_out, bd_out, valid_out, occ, empty
  );

endinterface

// File: rtl/pipe_stage_slot.sv
// One pipeline stage register with kill/hold/bubble/advance selection.
// Only the first stage of a chain ever sees bubble_i asserted.
module pipe_stage_slot
  import pipe_stage_chain_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter bit KEEP_PC_BUB = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_i,
  input  logic              stall_i,
  input  logic              bubble_i,
  input  stage_ctl_t        ctl_i,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  input  logic [PC_W-1:0]   pc_i,
  output stage_ctl_t        ctl_o,
  output logic [DATA_W-1:0] rs_o,
  output logic [DATA_W-1:0] rt_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              valid_d_o
);

  stage_ctl_t        ctl_q, ctl_d;
  logic [DATA_W-1:0] rs_q, rs_d;
  logic [DATA_W-1:0] rt_q, rt_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  stage_op_t         op;

  always_comb begin
    // NOTE: every next-state value is defaulted to "hold" before the case so no path infers a latch.
    ctl_d = ctl_q;
    rs_d  = rs_q;
    rt_d  = rt_q;
    pc_d  = pc_q;
    op    = stage_op(req_i, stall_i, bubble_i);
    unique case (op)
      OP_KILL: begin
        ctl_d = CTL_BUBBLE;
        rs_d  = '0;
        rt_d  = '0;
        pc_d  = '0;
      end
      OP_HOLD: begin
      end
      OP_BUBBLE: begin
        // A flushed slot keeps its delay-slot flag so CP0 still sees the branch shadow.
        ctl_d = bubble_ctl(ctl_i.bd);
        rs_d  = '0;
        rt_d  = '0;
        pc_d  = KEEP_PC_BUB ? pc_i : '0;
      end
      default: begin
        ctl_d = ctl_i;
        rs_d  = rs_i;
        rt_d  = rt_i;
        pc_d  = pc_i;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_q <= CTL_BUBBLE;
      rs_q  <= '0;
      rt_q  <= '0;
      pc_q  <= '0;
    end else begin
      ctl_q <= ctl_d;
      rs_q  <= rs_d;
      rt_q  <= rt_d;
      pc_q  <= pc_d;
    end
  end

  assign ctl_o     = ctl_q;
  assign rs_o      = rs_q;
  assign rt_o      = rt_q;
  assign pc_o      = pc_q;
  assign valid_d_o = ctl_d.valid;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage pipeline boundary with stall, flush-bubble and exception kill,
// plus a registered count of occupied stages for hazard/CP0 logic.
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter bit KEEP_PC_BUB = 1'b1
) (
  input logic               clk,
  input logic               reset,
  pipe_stage_chain_if.slave bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  // Index 0 is the incoming instruction; index k+1 is the output of stage k.
  stage_ctl_t        ctl_chain [0:DEPTH];
  logic [DATA_W-1:0] rs_chain  [0:DEPTH];
  logic [DATA_W-1:0] rt_chain  [0:DEPTH];
  logic [PC_W-1:0]   pc_chain  [0:DEPTH];
  logic [DEPTH-1:0]  valid_d;

  logic [OCC_W-1:0]  occ_d, occ_q;

  assign ctl_chain[0] = '{instr: bus.instr_in, exc: bus.exc_in, bd: bus.bd_in, valid: bus.valid_in};
  assign rs_chain[0]  = bus.rs_in;
  assign rt_chain[0]  = bus.rt_in;
  assign pc_chain[0]  = bus.pc_in;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_stage_slot #(
      .DATA_W      (DATA_W),
      .PC_W        (PC_W),
      .KEEP_PC_BUB (KEEP_PC_BUB)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .req_i     (bus.req),
      .stall_i   (bus.stall),
      .bubble_i  ((k == 0) ? bus.flush : 1'b0),
      .ctl_i     (ctl_chain[k]),
      .rs_i      (rs_chain[k]),
      .rt_i      (rt_chain[k]),
      .pc_i      (pc_chain[k]),
      .ctl_o     (ctl_chain[k+1]),
      .rs_o      (rs_chain[k+1]),
      .rt_o      (rt_chain[k+1]),
      .pc_o      (pc_chain[k+1]),
      .valid_d_o (valid_d[k])
    );
  end

  // Counting next-state valid bits keeps occ aligned with the stage contents.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OCC_W'(valid_d[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign bus.instr_out = ctl_chain[DEPTH].instr;
  assign bus.exc_out   = ctl_chain[DEPTH].exc;
  assign bus.bd_out    = ctl_chain[DEPTH].bd;
  assign bus.valid_out = ctl_chain[DEPTH].valid;
  assign bus.rs_out    = rs_chain[DEPTH];
  assign bus.rt_out    = rt_chain[DEPTH];
  assign bus.pc_out    = pc_chain[DEPTH];
  assign bus.occ       = occ_q;
  assign bus.empty     = (occ_q == '0);

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: a DEPTH=2/KEEP_PC_BUB=1 chain and a DEPTH=1/KEEP_PC_BUB=0
// legacy-equivalent register, both compared against a queue model of the pipeline.
module tb_pipe_stage_chain;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
    logic        valid;
  } rec_t;

  typedef rec_t rq_t[$];

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  rq_t  m2, m1;
  rec_t cur2, cur1;
  logic st2, fl2, rq2, st1, fl1, rq1;

  pipe_stage_chain_if #(.DEPTH(2), .DATA_W(32), .PC_W(32)) bus2 ();
  pipe_stage_chain_if #(.DEPTH(1), .DATA_W(32), .PC_W(32)) bus1 ();

  pipe_stage_chain #(.DEPTH(2), .DATA_W(32), .PC_W(32), .KEEP_PC_BUB(1'b1)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );
  pipe_stage_chain #(.DEPTH(1), .DATA_W(32), .PC_W(32), .KEEP_PC_BUB(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model: pipeline as a fixed-length queue ----------------
  function automatic rq_t model_clear(input int depth);
    rq_t q;
    q = {};
    for (int i = 0; i < depth; i++) q.push_back('0);
    return q;
  endfunction

  function automatic rq_t model_edge(input rq_t q, input rec_t in, input logic req,
                                     input logic stall, input logic flush, input bit keep_pc);
    rq_t  r;
    rec_t e;
    r = q;
    if (req) begin
      foreach (r[i]) r[i] = '0;
    end else if (!stall) begin
      e = in;
      if (flush) begin
        e    = '0;
        e.bd = in.bd;
        e.pc = keep_pc ? in.pc : 32'h0;
      end
      r.push_front(e);
      void'(r.pop_back());
    end
    return r;
  endfunction

  function automatic logic [31:0] model_occ(input rq_t q);
    logic [31:0] n;
    n = 0;
    foreach (q[i]) if (q[i].valid) n++;
    return n;
  endfunction

  function automatic rec_t model_out(input rq_t q);
    return q[q.size()-1];
  endfunction

  function automatic rec_t obs2();
    return '{instr: bus2.instr_out, rs: bus2.rs_out, rt: bus2.rt_out, pc: bus2.pc_out,
             exc: bus2.exc_out, bd: bus2.bd_out, valid: bus2.valid_out};
  endfunction

  function automatic rec_t obs1();
    return '{instr: bus1.instr_out, rs: bus1.rs_out, rt: bus1.rt_out, pc: bus1.pc_out,
             exc: bus1.exc_out, bd: bus1.bd_out, valid: bus1.valid_out};
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r.instr = $urandom;
    r.rs    = $urandom;
    r.rt    = $urandom;
    r.pc    = $urandom & 32'hFFFF_FFFC;
    r.exc   = 5'($urandom_range(0, 31));
    r.bd    = 1'($urandom_range(0, 1));
    r.valid = ($urandom_range(0, 3) != 0);
    return r;
  endfunction

  function automatic rec_t mk_rec(input logic [31:0] pc, input logic bd, input logic valid);
    rec_t r;
    r       = rand_rec();
    r.pc    = pc;
    r.bd    = bd;
    r.valid = valid;
    return r;
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic drive2(input rec_t r, input logic st, input logic fl, input logic rq);
    cur2 = r; st2 = st; fl2 = fl; rq2 = rq;
    bus2.instr_in = r.instr; bus2.rs_in = r.rs; bus2.rt_in = r.rt; bus2.pc_in = r.pc;
    bus2.exc_in = r.exc; bus2.bd_in = r.bd; bus2.valid_in = r.valid;
    bus2.stall = st; bus2.flush = fl; bus2.req = rq;
  endtask

  task automatic drive1(input rec_t r, input logic st, input logic fl, input logic rq);
    cur1 = r; st1 = st; fl1 = fl; rq1 = rq;
    bus1.instr_in = r.instr; bus1.rs_in = r.rs; bus1.rt_in = r.rt; bus1.pc_in = r.pc;
    bus1.exc_in = r.exc; bus1.bd_in = r.bd; bus1.valid_in = r.valid;
    bus1.stall = st; bus1.flush = fl; bus1.req = rq;
  endtask

  // Advance models for the coming edge, then sample 1 time unit after it.
  task automatic edge_step();
    if (reset) begin
      m2 = model_clear(2);
      m1 = model_clear(1);
    end else begin
      m2 = model_edge(m2, cur2, rq2, st2, fl2, 1'b1);
      m1 = model_edge(m1, cur1, rq1, st1, fl1, 1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m2 = model_clear(2);
    m1 = model_clear(1);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    n_tests++;
    if (obs2() !== rec_t'(0)) begin
      n_fail++; $display("FAIL reset_out2: got %h expected 0", obs2());
    end
    n_tests++;
    if (bus2.occ !== 2'd0 || bus2.empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_occ2: got occ=%0d empty=%b expected occ=0 empty=1", bus2.occ, bus2.empty);
    end
    n_tests++;
    if (obs1() !== rec_t'(0) || bus1.occ !== 1'b0 || bus1.empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_dut1: got %h occ=%0d empty=%b expected all 0, empty=1", obs1(), bus1.occ, bus1.empty);
    end
    do_reset();
  endtask

  task automatic test_fill();
    logic [31:0] exp_pc  [3];
    logic [31:0] exp_occ [3];
    exp_pc  = '{32'h0, 32'h3000, 32'h3004};
    exp_occ = '{32'd1, 32'd2, 32'd2};
    do_reset();
    n_tests++;
    if (bus2.occ !== 2'd0) begin
      n_fail++; $display("FAIL fill_occ_start: got %0d expected 0", bus2.occ);
    end
    for (int i = 0; i < 3; i++) begin
      drive2(mk_rec(32'h3000 + 32'(4 * i), 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      edge_step();
      n_tests++;
      if (bus2.pc_out !== exp_pc[i] || 32'(bus2.occ) !== exp_occ[i]) begin
        n_fail++; $display("FAIL fill_edge%0d: got pc=%h occ=%0d expected pc=%h occ=%0d",
                           i + 1, bus2.pc_out, bus2.occ, exp_pc[i], exp_occ[i]);
      end
      n_tests++;
      if (obs2() !== model_out(m2)) begin
        n_fail++; $display("FAIL fill_fields%0d: got %h expected %h", i + 1, obs2(), model_out(m2));
      end
    end
  endtask

  // Continues from the full chain left by test_fill: stage1=0x3004, stage0=0x3008.
  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive2(mk_rec(32'h300C, 1'b0, 1'b1), 1'b1, (i == 1), 1'b0);
      edge_step();
      n_tests++;
      if (bus2.pc_out !== 32'h3004 || bus2.occ !== 2'd2 || obs2() !== model_out(m2)) begin
        n_fail++; $display("FAIL stall_hold%0d: got %h occ=%0d expected %h occ=2",
                           i, obs2(), bus2.occ, model_out(m2));
      end
    end
    drive2(mk_rec(32'h300C, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
    edge_step();
    n_tests++;
    if (bus2.pc_out !== 32'h3008 || bus2.valid_out !== 1'b1 || bus2.occ !== 2'd2) begin
      n_fail++; $display("FAIL stall_resume: got pc=%h valid=%b occ=%0d expected pc=00003008 valid=1 occ=2",
                         bus2.pc_out, bus2.valid_out, bus2.occ);
    end
  endtask

  // Chain now: stage1=0x3008, stage0=0x300C, both valid.
  task automatic test_flush();
    drive2(mk_rec(32'h3010, 1'b1, 1'b1), 1'b0, 1'b1, 1'b0);
    edge_step();
    n_tests++;
    if (bus2.pc_out !== 32'h300C || bus2.valid_out !== 1'b1 || bus2.occ !== 2'd1) begin
      n_fail++; $display("FAIL flush_edge1: got pc=%h valid=%b occ=%0d expected pc=0000300c valid=1 occ=1",
                         bus2.pc_out, bus2.valid_out, bus2.occ);
    end
    drive2(mk_rec(32'h3014, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
    edge_step();
    n_tests++;
    if (bus2.valid_out !== 1'b0 || bus2.bd_out !== 1'b1 || bus2.pc_out !== 32'h3010 ||
        bus2.instr_out !== 32'h0 || bus2.exc_out !== 5'h0 || bus2.rs_out !== 32'h0 || bus2.rt_out !== 32'h0) begin
      n_fail++; $display("FAIL flush_bubble_out: got %h expected instr/rs/rt/exc/valid 0, bd=1, pc=00003010", obs2());
    end
    n_tests++;
    if (bus2.occ !== 2'd1 || obs2() !== model_out(m2)) begin
      n_fail++; $display("FAIL flush_edge2: got %h occ=%0d expected %h occ=1", obs2(), bus2.occ, model_out(m2));
    end
  endtask

  task automatic test_req_over_stall();
    drive2(mk_rec(32'h4000, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0);
    edge_step();
    drive2(mk_rec(32'h4004, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
    edge_step();
    n_tests++;
    if (bus2.occ !== 2'd2) begin
      n_fail++; $display("FAIL req_setup_occ: got %0d expected 2", bus2.occ);
    end
    drive2(mk_rec(32'h4008, 1'b1, 1'b1), 1'b1, 1'b1, 1'b1);
    edge_step();
    n_tests++;
    if (obs2() !== rec_t'(0) || bus2.occ !== 2'd0 || bus2.empty !== 1'b1) begin
      n_fail++; $display("FAIL req_kill: got %h occ=%0d empty=%b expected all 0, empty=1",
                         obs2(), bus2.occ, bus2.empty);
    end
    // Killed chain must refill cleanly.
    drive2(mk_rec(32'h400C, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
    edge_step();
    edge_step();
    n_tests++;
    if (bus2.pc_out !== 32'h400C || bus2.occ !== 2'd2) begin
      n_fail++; $display("FAIL req_refill: got pc=%h occ=%0d expected pc=0000400c occ=2", bus2.pc_out, bus2.occ);
    end
  endtask

  task automatic test_async_reset();
    drive2(mk_rec(32'h5000, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0);
    edge_step();
    edge_step();
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (obs2() !== rec_t'(0) || bus2.occ !== 2'd0 || bus2.empty !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: got %h occ=%0d empty=%b expected all 0, empty=1 before edge",
                         obs2(), bus2.occ, bus2.empty);
    end
    m2 = model_clear(2);
    m1 = model_clear(1);
    #1;
    reset = 1'b0;
    drive2(mk_rec(32'h5008, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
    edge_step();
    n_tests++;
    if (bus2.occ !== 2'd1 || bus2.valid_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_load: got occ=%0d valid_out=%b expected occ=1 valid_out=0",
                         bus2.occ, bus2.valid_out);
    end
    edge_step();
    n_tests++;
    if (bus2.pc_out !== 32'h5008 || obs2() !== model_out(m2)) begin
      n_fail++; $display("FAIL reset_release_out: got %h expected %h", obs2(), model_out(m2));
    end
  endtask

  task automatic test_random_chain();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive2(rand_rec(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 15) == 0));
      edge_step();
      n_tests++;
      if (obs2() !== model_out(m2) || 32'(bus2.occ) !== model_occ(m2) ||
          bus2.empty !== (model_occ(m2) == 0)) begin
        n_fail++;
        if (errs < 8) $display("FAIL rand_chain cycle%0d: got %h occ=%0d expected %h occ=%0d",
                               i, obs2(), bus2.occ, model_out(m2), model_occ(m2));
        errs++;
      end
    end
  endtask

  task automatic test_legacy_depth1();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive1(rand_rec(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 11) == 0));
      edge_step();
      n_tests++;
      if (obs1() !== model_out(m1) || 32'(bus1.occ) !== model_occ(m1) ||
          bus1.empty !== (model_occ(m1) == 0)) begin
        n_fail++;
        if (errs < 8) $display("FAIL legacy_d1 cycle%0d: got %h occ=%0d expected %h occ=%0d",
                               i, obs1(), bus1.occ, model_out(m1), model_occ(m1));
        errs++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    m2 = model_clear(2);
    m1 = model_clear(1);
    drive2('0, 1'b0, 1'b0, 1'b0);
    drive1('0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_fill();
    test_stall();
    test_flush();
    test_req_over_stall();
    test_async_reset();
    test_random_chain();
    test_legacy_depth1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
